// File: rtl/vga_reg_bank_shadow_pkg.sv
// Shared definitions for the double-buffered VGA register bank.
//   MODE_*          per-register access mode encodings (2 bits each in REG_MODE)
//   commit_state_t  commit FSM state encoding
package vga_reg_bank_shadow_pkg;

    localparam logic [1:0] MODE_SHADOW = 2'd0;  // staged, reaches active on commit
    localparam logic [1:0] MODE_IMMED  = 2'd1;  // staging and active written together
    localparam logic [1:0] MODE_RO     = 2'd2;  // live status from ro_in, writes ignored
    localparam logic [1:0] MODE_W1C    = 2'd3;  // sticky flags, set by hardware, cleared by writing 1

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } commit_state_t;

endpackage

// File: rtl/vga_reg_bank_shadow_cell.sv
// One register of the bank: staging copy, active copy and mode-specific update rules.
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en       write to this register (address already decoded)
//   wr_data     write data
//   wr_strb     byte enables
//   transfer    commit moment: SHADOW registers copy staging into active
//   sts_set     hardware set pulses (W1C mode only)
//   staging     staging copy (what a host read of a SHADOW register sees)
//   active      active copy (what the datapath sees)
module vga_reg_bank_shadow_cell
    import vga_reg_bank_shadow_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [1:0]            MODE       = MODE_SHADOW,
    parameter logic [DATA_WIDTH-1:0] DFLT       = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    transfer,
    input  logic [DATA_WIDTH-1:0]   sts_set,
    output logic [DATA_WIDTH-1:0]   staging,
    output logic [DATA_WIDTH-1:0]   active
);

    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] clr;
    logic [DATA_WIDTH-1:0] staging_nxt;
    logic [DATA_WIDTH-1:0] active_nxt;

    always_comb begin
        mask = '0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            mask[b*8 +: 8] = {8{wr_strb[b]}};
        end
        merged = (staging & ~mask) | (wr_data & mask);
        clr    = wr_en ? (wr_data & mask) : '0;

        staging_nxt = staging;
        active_nxt  = active;
        case (MODE)
            MODE_SHADOW: begin
                if (wr_en) staging_nxt = merged;
                // active takes the pre-write staging value when a write and
                // a transfer coincide
                if (transfer) active_nxt = staging;
            end
            MODE_IMMED: begin
                if (wr_en) begin
                    staging_nxt = merged;
                    active_nxt  = merged;
                end
            end
            MODE_W1C: begin
                // OR-ing the set term last makes set win over clear
                active_nxt = (active & ~clr) | sts_set;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= DFLT;
            active  <= DFLT;
        end else begin
            staging <= staging_nxt;
            active  <= active_nxt;
        end
    end

    // Some inputs are dead for particular modes; fold them into a sink.
    logic unused_cell;
    assign unused_cell = ^{clr, merged, transfer, sts_set};

endmodule

// File: rtl/vga_reg_bank_shadow.sv
// Double-buffered control register bank for the VGA controller.
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_strb   host write port, one write per cycle
//   rd_en/rd_addr              host read request
//   rd_data/rd_valid           read response
//   addr_err                   pulse for an access with index >= NUM_REGS
//   commit_req                 arm a staging->active transfer of SHADOW registers
//   frame_start                frame boundary pulse from the timing generator
//   commit_pend                armed, waiting for frame_start (exposes FSM state)
//   commit_done                pulse the cycle after a transfer
//   ro_in                      live values for RO registers
//   sts_set                    set pulses for W1C registers
//   reg_out                    active register values to the datapath
//
// Read handshake: there is no backpressure. rd_en is accepted every cycle it
// is high; exactly one cycle later rd_valid is high for one cycle and rd_data
// holds the response (held afterwards until the next accepted read).
module vga_reg_bank_shadow
    import vga_reg_bank_shadow_pkg::*;
#(
    parameter int                               DATA_WIDTH = 32,
    parameter int                               NUM_REGS   = 8,
    parameter int                               ADDR_WIDTH = 3,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   DFLT_VALUE = '0,
    parameter logic [2*NUM_REGS-1:0]            REG_MODE   = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/8-1:0]          wr_strb,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             addr_err,
    input  logic                             commit_req,
    input  logic                             frame_start,
    output logic                             commit_pend,
    output logic                             commit_done,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   ro_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   sts_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out
);

    commit_state_t          state;
    logic                   transfer;
    logic                   wr_ok;
    logic                   rd_ok;
    logic [DATA_WIDTH-1:0]  rd_next;
    logic [DATA_WIDTH-1:0]  staging_a [NUM_REGS];
    logic [DATA_WIDTH-1:0]  active_a  [NUM_REGS];

    assign wr_ok    = 32'(wr_addr) < NUM_REGS;
    assign rd_ok    = 32'(rd_addr) < NUM_REGS;
    assign transfer = (state == ST_ARMED) && frame_start;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [1:0] MODE = REG_MODE[2*i +: 2];
        logic hit;
        assign hit = wr_en && (wr_addr == ADDR_WIDTH'(i));

        vga_reg_bank_shadow_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (MODE),
            .DFLT       (DFLT_VALUE[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (hit),
            .wr_data  (wr_data),
            .wr_strb  (wr_strb),
            .transfer (transfer),
            .sts_set  (sts_set[i*DATA_WIDTH +: DATA_WIDTH]),
            .staging  (staging_a[i]),
            .active   (active_a[i])
        );

        // RO registers pass status straight through to the datapath
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] =
            (MODE == MODE_RO) ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : active_a[i];
    end

    // Read mux; an out-of-range index falls through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                case (REG_MODE[2*i +: 2])
                    MODE_SHADOW: rd_next = staging_a[i];
                    MODE_RO:     rd_next = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
                    default:     rd_next = active_a[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_next;
            addr_err <= (rd_en && !rd_ok) || (wr_en && !wr_ok);
        end
    end

    // Commit FSM. A commit_req that coincides with frame_start in IDLE only
    // arms, so the transfer always lands on a full frame boundary later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            commit_done <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (commit_req) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (frame_start) begin
                        state       <= ST_IDLE;
                        commit_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign commit_pend = (state == ST_ARMED);

    // Staging copies of non-SHADOW registers never reach the read mux.
    logic unused_staging;
    always_comb begin
        unused_staging = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            unused_staging = unused_staging ^ (^staging_a[i]);
        end
    end

endmodule

// File: tb/tb_vga_reg_bank_shadow.sv
// Directed self-checking bench for vga_reg_bank_shadow.
// Register map used: r0 SHADOW, r1 IMMED, r2 RO, r3 W1C, r4..r7 SHADOW.
module tb_vga_reg_bank_shadow;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 4;
    localparam logic [NR*DW-1:0] DFLT = {
        32'h0000_0000, 32'h0000_0000, 32'h55AA_55AA, 32'hDEAD_BEEF,
        32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1111_0000
    };
    localparam logic [2*NR-1:0] MODES = 16'h00E4;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DW/8-1:0]   wr_strb;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              addr_err;
    logic              commit_req;
    logic              frame_start;
    logic              commit_pend;
    logic              commit_done;
    logic [NR*DW-1:0]  ro_in;
    logic [NR*DW-1:0]  sts_set;
    logic [NR*DW-1:0]  reg_out;

    int checks = 0;
    int errors = 0;

    vga_reg_bank_shadow #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW),
        .DFLT_VALUE (DFLT),
        .REG_MODE   (MODES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .addr_err    (addr_err),
        .commit_req  (commit_req),
        .frame_start (frame_start),
        .commit_pend (commit_pend),
        .commit_done (commit_done),
        .ro_in       (ro_in),
        .sts_set     (sts_set),
        .reg_out     (reg_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] slot(input logic [NR*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_strb = s;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp_data, input logic exp_err);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        check({tag, "_data"},  rd_data, exp_data);
        check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
        check({tag, "_err"},   {31'b0, addr_err}, {31'b0, exp_err});
    endtask

    task automatic check_defaults(input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_r%0d", tag, i), slot(reg_out, i),
                  (i == 2) ? slot(ro_in, 2) : slot(DFLT, i));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_strb     = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        commit_req  = 1'b0;
        frame_start = 1'b0;
        sts_set     = '0;
        ro_in       = '0;
        ro_in[0*DW +: DW] = 32'hBAD0_BAD0;   // ignored slice
        ro_in[2*DW +: DW] = 32'hCAFE_F00D;

        // reset state
        step();
        step();
        check_defaults("rst");
        check("rst_rd_data",     rd_data, 32'h0);
        check("rst_rd_valid",    {31'b0, rd_valid}, 32'd0);
        check("rst_addr_err",    {31'b0, addr_err}, 32'd0);
        check("rst_commit_pend", {31'b0, commit_pend}, 32'd0);
        check("rst_commit_done", {31'b0, commit_done}, 32'd0);
        rst_n = 1'b1;
        step();

        // SHADOW write stays in staging
        do_write(4'd0, 32'hA5A5_A5A5, 4'hF);
        check("shadow_active_hold", slot(reg_out, 0), 32'h1111_0000);
        do_read("shadow_rd", 4'd0, 32'hA5A5_A5A5, 1'b0);

        // commit: armed for three cycles, transfer on frame_start
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("pend_wait%0d", k), {31'b0, commit_pend}, 32'd1);
            check($sformatf("hold_wait%0d", k), slot(reg_out, 0), 32'h1111_0000);
            step();
        end
        check("pend_before_fs", {31'b0, commit_pend}, 32'd1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("commit_r0",      slot(reg_out, 0), 32'hA5A5_A5A5);
        check("commit_done_hi", {31'b0, commit_done}, 32'd1);
        check("commit_pend_lo", {31'b0, commit_pend}, 32'd0);
        step();
        check("commit_done_lo", {31'b0, commit_done}, 32'd0);

        // IMMED byte-strobed write over 0xFFFFFFFF
        do_write(4'd1, 32'h1234_5678, 4'b0011);
        check("immed_r1", slot(reg_out, 1), 32'hFFFF_5678);
        do_read("immed_rd", 4'd1, 32'hFFFF_5678, 1'b0);

        // RO: write ignored, read and reg_out follow ro_in
        do_write(4'd2, 32'hFFFF_FFFF, 4'hF);
        check("ro_wr_ignored", slot(reg_out, 2), 32'hCAFE_F00D);
        ro_in[2*DW +: DW] = 32'h1357_9BDF;
        #1;
        check("ro_passthru", slot(reg_out, 2), 32'h1357_9BDF);
        do_read("ro_rd", 4'd2, 32'h1357_9BDF, 1'b0);

        // W1C: set 0x0F, clear 0x05 -> 0x0A; set+clear bit0 -> set wins
        sts_set[3*DW +: DW] = 32'h0000_000F;
        step();
        sts_set = '0;
        check("w1c_set", slot(reg_out, 3), 32'h0000_000F);
        do_write(4'd3, 32'h0000_0005, 4'hF);
        do_read("w1c_rd", 4'd3, 32'h0000_000A, 1'b0);
        sts_set[3*DW +: DW] = 32'h0000_0001;
        do_write(4'd3, 32'h0000_0001, 4'hF);
        sts_set = '0;
        check("w1c_set_wins", slot(reg_out, 3), 32'h0000_000B);

        // write and transfer in the same cycle while ARMED
        do_write(4'd5, 32'h0102_0304, 4'hF);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        frame_start = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 32'hAABB_CCDD;
        wr_strb = 4'hF;
        step();
        frame_start = 1'b0;
        wr_en = 1'b0;
        check("race_active_old", slot(reg_out, 5), 32'h0102_0304);
        check("race_done",       {31'b0, commit_done}, 32'd1);
        check("race_immed_kept", slot(reg_out, 1), 32'hFFFF_5678);
        do_read("race_staging", 4'd5, 32'hAABB_CCDD, 1'b0);

        // commit_req with frame_start in IDLE arms only
        do_write(4'd4, 32'h0BAD_CAFE, 4'hF);
        commit_req  = 1'b1;
        frame_start = 1'b1;
        step();
        commit_req  = 1'b0;
        frame_start = 1'b0;
        check("armonly_pend", {31'b0, commit_pend}, 32'd1);
        check("armonly_r4",   slot(reg_out, 4), 32'hDEAD_BEEF);
        check("armonly_done", {31'b0, commit_done}, 32'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("next_frame_r4", slot(reg_out, 4), 32'h0BAD_CAFE);
        check("next_frame_r5", slot(reg_out, 5), 32'hAABB_CCDD);

        // frame_start in IDLE: no transfer
        do_write(4'd6, 32'h0000_0066, 4'hF);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("idle_fs_r6",   slot(reg_out, 6), 32'h0);
        check("idle_fs_done", {31'b0, commit_done}, 32'd0);

        // out-of-range accesses
        do_read("bad_rd", 4'd9, 32'h0, 1'b1);
        do_write(4'd12, 32'hFFFF_FFFF, 4'hF);
        check("bad_wr_err", {31'b0, addr_err}, 32'd1);
        check("bad_wr_r1",  slot(reg_out, 1), 32'hFFFF_5678);
        check("bad_wr_r4",  slot(reg_out, 4), 32'h0BAD_CAFE);
        step();
        check("err_clears", {31'b0, addr_err}, 32'd0);

        // asynchronous reset while ARMED drops the pending commit
        do_write(4'd7, 32'h7777_7777, 4'hF);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("pre_rst_pend", {31'b0, commit_pend}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pend", {31'b0, commit_pend}, 32'd0);
        check_defaults("async_rst");
        step();
        rst_n = 1'b1;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("post_rst_r7",   slot(reg_out, 7), 32'h0);
        check("post_rst_done", {31'b0, commit_done}, 32'd0);
        do_read("post_rst_rd7", 4'd7, 32'h0, 1'b0);
        do_read("post_rst_rd0", 4'd0, 32'h1111_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
